// File: rtl/mem_wb_stage_pkg.sv
// Shared MEM/WB definitions: WB control bit positions, default widths and the
// pipeline entry layout reused by neighbouring pipeline stages.
package mem_wb_stage_pkg;

   // Bit positions inside the WB control bundle; bits above these are carried untouched.
   localparam int unsigned WB_REGWRITE = 0;
   localparam int unsigned WB_MEMTOREG = 1;

   // Default datapath widths for a 32-bit RISC-style core.
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_REG_AW = 5;
   localparam int unsigned DEF_WB_W   = 2;

   // Entry carried between MEM and WB at the default widths.
   typedef struct packed {
      logic [DEF_WB_W-1:0]   wb;
      logic [DEF_DATA_W-1:0] rdata;
      logic [DEF_DATA_W-1:0] alu;
      logic [DEF_REG_AW-1:0] rd;
   } mem_wb_entry_t;

   // Packed width of one entry for arbitrary parameterisation.
   function automatic int unsigned entry_width(input int unsigned data_w,
                                               input int unsigned reg_aw,
                                               input int unsigned wb_w);
      return wb_w + 2 * data_w + reg_aw;
   endfunction

endpackage

// File: rtl/mem_wb_stage_skid_buf.sv
// Generic valid/ready pipeline register with an optional second (skid) entry.
// With SKID_EN=1 ready_o is a pure register output, so the upstream never sees
// a combinational path from ready_i; the skid slot absorbs the one entry that
// arrives in the cycle the head stalls. With SKID_EN=0 it degrades to a single
// register whose ready_o follows ready_i combinationally.
module pipe_skid_buf #(
   parameter int unsigned W       = 8,
   parameter bit          SKID_EN = 1'b1
) (
   input  logic         clk_i,
   input  logic         rst_i,    // synchronous, active-low
   input  logic         flush_i,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] data_o
);

   logic         head_v_q, head_v_d;
   logic         skid_v_q, skid_v_d;
   logic [W-1:0] head_q,   head_d;
   logic [W-1:0] skid_q,   skid_d;
   logic         accept;
   logic         pop;

   // Upstream ready: registered skid state, or pass-through stall in single-entry mode.
   always_comb begin
      if (SKID_EN) begin
         ready_o = ~skid_v_q;
      end else begin
         ready_o = ~head_v_q | ready_i;
      end
   end

   assign accept = valid_i & ready_o;
   assign pop    = head_v_q & ready_i;

   // Next-state: refill head from skid first (keeps FIFO order), else from input;
   // a stalled full head diverts the accepted input into the skid slot.
   always_comb begin
      head_v_d = head_v_q;
      skid_v_d = skid_v_q;
      head_d   = head_q;
      skid_d   = skid_q;
      if (flush_i) begin
         // Data registers keep stale contents; only the valid bits matter.
         head_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (!head_v_q || pop) begin
         if (skid_v_q) begin
            head_v_d = 1'b1;
            head_d   = skid_q;
            skid_v_d = 1'b0;
         end else begin
            head_v_d = accept;
            if (accept) begin
               head_d = data_i;
            end
         end
      end else if (accept && SKID_EN) begin
         skid_v_d = 1'b1;
         skid_d   = data_i;
      end
   end

   // State registers; reset clears valids and data so outputs read as zero.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         head_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         head_q   <= '0;
         skid_q   <= '0;
      end else begin
         head_v_q <= head_v_d;
         skid_v_q <= skid_v_d;
         head_q   <= head_d;
         skid_q   <= skid_d;
      end
   end

   assign valid_o = head_v_q;
   assign data_o  = head_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage. Buffers WB control, load data, ALU result and
// destination index behind a valid/ready handshake, then presents the head
// entry with a decoded register-write strobe and the pre-selected writeback
// value that both the register file and the forwarding unit consume.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned REG_AW  = DEF_REG_AW,
   parameter int unsigned WB_W    = DEF_WB_W,
   parameter bit          SKID_EN = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,      // synchronous, active-low
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [WB_W-1:0]   WB_i,
   input  logic [DATA_W-1:0] ReadData_i,
   input  logic [DATA_W-1:0] ALU_i,
   input  logic [REG_AW-1:0] rd_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [WB_W-1:0]   WB_o,
   output logic              MemtoReg_o,
   output logic              RegWrite_o,
   output logic [DATA_W-1:0] ReadData_o,
   output logic [DATA_W-1:0] ALU_o,
   output logic [REG_AW-1:0] rd_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic              fwd_en_o
);

   localparam int unsigned EntryW = entry_width(DATA_W, REG_AW, WB_W);

   logic [EntryW-1:0] in_entry;
   logic [EntryW-1:0] head_entry;

   assign in_entry = {WB_i, ReadData_i, ALU_i, rd_i};

   pipe_skid_buf #(
      .W       (EntryW),
      .SKID_EN (SKID_EN)
   ) u_buf (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (in_entry),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (head_entry)
   );

   assign {WB_o, ReadData_o, ALU_o, rd_o} = head_entry;

   // Head decode: bubbles and x0 never write or forward; writeback value is
   // selected here so consumers see a single registered-source mux.
   always_comb begin
      MemtoReg_o = WB_o[WB_MEMTOREG];
      RegWrite_o = WB_o[WB_REGWRITE] & valid_o & (rd_o != '0);
      fwd_en_o   = RegWrite_o;
      wb_data_o  = MemtoReg_o ? ReadData_o : ALU_o;
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios with inline checks
// plus a scoreboard that predicts every entry popped at the WB side.
module tb_mem_wb_stage;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned WW = 3;   // one pass-through bit above MemtoReg

   logic          clk;
   logic          rst_i, flush_i, valid_i, ready_o, ready_i, valid_o;
   logic          MemtoReg_o, RegWrite_o, fwd_en_o;
   logic [WW-1:0] WB_i, WB_o;
   logic [DW-1:0] ReadData_i, ALU_i, ReadData_o, ALU_o, wb_data_o;
   logic [AW-1:0] rd_i, rd_o;

   typedef struct packed {
      logic [WW-1:0] wb;
      logic [DW-1:0] rdata;
      logic [DW-1:0] alu;
      logic [AW-1:0] rd;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   mem_wb_stage #(
      .DATA_W  (DW),
      .REG_AW  (AW),
      .WB_W    (WW),
      .SKID_EN (1'b1)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .flush_i    (flush_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .WB_i       (WB_i),
      .ReadData_i (ReadData_i),
      .ALU_i      (ALU_i),
      .rd_i       (rd_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .WB_o       (WB_o),
      .MemtoReg_o (MemtoReg_o),
      .RegWrite_o (RegWrite_o),
      .ReadData_o (ReadData_o),
      .ALU_o      (ALU_o),
      .rd_o       (rd_o),
      .wb_data_o  (wb_data_o),
      .fwd_en_o   (fwd_en_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [WW-1:0] wb, input logic [DW-1:0] rdata,
                        input logic [DW-1:0] alu, input logic [AW-1:0] rd);
      valid_i    = v;
      WB_i       = wb;
      ReadData_i = rdata;
      ALU_i      = alu;
      rd_i       = rd;
   endtask

   // Predicts pushes on accepted inputs and checks every popped head entry.
   task automatic scoreboard_monitor();
      exp_t          e;
      logic          exp_rw;
      logic [DW-1:0] exp_wd;
      forever begin
         @(negedge clk);
         if (!rst_i || flush_i) begin
            sb_q.delete();
         end else begin
            if (valid_o && ready_i) begin
               n_cmp++;
               if (sb_q.size() == 0) begin
                  n_err++;
                  $display("FAIL sb_unexpected: got rd=%0d alu=%h, required no entry", rd_o, ALU_o);
               end else begin
                  e      = sb_q.pop_front();
                  exp_rw = e.wb[0] && (e.rd != '0);
                  exp_wd = e.wb[1] ? e.rdata : e.alu;
                  if ({WB_o, ReadData_o, ALU_o, rd_o, wb_data_o, RegWrite_o, fwd_en_o} !==
                      {e.wb, e.rdata, e.alu, e.rd, exp_wd, exp_rw, exp_rw}) begin
                     n_err++;
                     $display("FAIL sb_entry: got wb=%b rdata=%h alu=%h rd=%0d wbd=%h rw=%b fwd=%b, required wb=%b rdata=%h alu=%h rd=%0d wbd=%h rw=%b",
                              WB_o, ReadData_o, ALU_o, rd_o, wb_data_o, RegWrite_o, fwd_en_o,
                              e.wb, e.rdata, e.alu, e.rd, exp_wd, exp_rw);
                  end
               end
            end
            if (valid_i && ready_o) begin
               sb_q.push_back({WB_i, ReadData_i, ALU_i, rd_i});
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_i   = 1'b0;
      flush_i = 1'b0;
      ready_i = 1'b1;
      drive(1'b1, 3'b011, 32'hCAFE_F00D, 32'h55, 5'd7);
      cyc();
      cyc();
      n_cmp++;
      if ({valid_o, ready_o, RegWrite_o, fwd_en_o} !== 4'b0100) begin
         n_err++;
         $display("FAIL reset_ctrl: got v/r/rw/fwd=%b, required 0100",
                  {valid_o, ready_o, RegWrite_o, fwd_en_o});
      end
      n_cmp++;
      if ({WB_o, ReadData_o, ALU_o, rd_o, wb_data_o} !== '0) begin
         n_err++;
         $display("FAIL reset_data: got wb=%b rdata=%h alu=%h rd=%0d wbd=%h, required all 0",
                  WB_o, ReadData_o, ALU_o, rd_o, wb_data_o);
      end
      rst_i   = 1'b1;
      valid_i = 1'b0;
      cyc();
      n_cmp++;
      if (valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: got valid_o=%b, required 0", valid_o);
      end
   endtask

   task automatic test_stream();
      ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 3'b001, $urandom, 32'h10 + i, 5'd3);
         cyc();
         n_cmp++;
         if ({valid_o, ready_o, RegWrite_o, wb_data_o} !== {3'b111, 32'h10 + i}) begin
            n_err++;
            $display("FAIL stream_%0d: got v/r/rw=%b wbd=%h, required 111 wbd=%h", i,
                     {valid_o, ready_o, RegWrite_o}, wb_data_o, 32'h10 + i);
         end
      end
      valid_i = 1'b0;
      cyc();
      n_cmp++;
      if (valid_o !== 1'b0 || sb_q.size() != 0) begin
         n_err++;
         $display("FAIL stream_drain: got valid_o=%b pending=%0d, required 0 and 0",
                  valid_o, sb_q.size());
      end
   endtask

   task automatic test_stall();
      ready_i = 1'b0;
      drive(1'b1, 3'b001, 32'h0, 32'hA0, 5'd1);
      cyc();
      n_cmp++;
      if ({valid_o, ready_o, ALU_o} !== {2'b11, 32'hA0}) begin
         n_err++;
         $display("FAIL stall_first: got v/r=%b alu=%h, required 11 alu=a0", {valid_o, ready_o}, ALU_o);
      end
      drive(1'b1, 3'b001, 32'h0, 32'hB0, 5'd2);
      cyc();
      n_cmp++;
      if ({ready_o, ALU_o} !== {1'b0, 32'hA0}) begin
         n_err++;
         $display("FAIL stall_skid: got ready_o=%b alu=%h, required 0 alu=a0", ready_o, ALU_o);
      end
      drive(1'b1, 3'b001, 32'h0, 32'hC0, 5'd4);
      cyc();
      n_cmp++;
      if ({ready_o, ALU_o} !== {1'b0, 32'hA0}) begin
         n_err++;
         $display("FAIL stall_hold: got ready_o=%b alu=%h, required 0 alu=a0", ready_o, ALU_o);
      end
      ready_i = 1'b1;
      cyc();
      n_cmp++;
      if ({ready_o, ALU_o} !== {1'b1, 32'hB0}) begin
         n_err++;
         $display("FAIL stall_drain_b: got ready_o=%b alu=%h, required 1 alu=b0", ready_o, ALU_o);
      end
      cyc();
      n_cmp++;
      if ({valid_o, ALU_o} !== {1'b1, 32'hC0}) begin
         n_err++;
         $display("FAIL stall_drain_c: got valid_o=%b alu=%h, required 1 alu=c0", valid_o, ALU_o);
      end
      valid_i = 1'b0;
      cyc();
      n_cmp++;
      if (valid_o !== 1'b0 || sb_q.size() != 0) begin
         n_err++;
         $display("FAIL stall_empty: got valid_o=%b pending=%0d, required 0 and 0",
                  valid_o, sb_q.size());
      end
   endtask

   task automatic test_load();
      ready_i = 1'b1;
      drive(1'b1, 3'b011, 32'hDEAD_BEEF, 32'h4, 5'd5);
      cyc();
      n_cmp++;
      if ({wb_data_o, MemtoReg_o, RegWrite_o, fwd_en_o} !== {32'hDEAD_BEEF, 3'b111}) begin
         n_err++;
         $display("FAIL load: got wbd=%h m2r/rw/fwd=%b, required deadbeef 111", wb_data_o,
                  {MemtoReg_o, RegWrite_o, fwd_en_o});
      end
      drive(1'b1, 3'b101, 32'h1234_5678, 32'h9, 5'd6);
      cyc();
      n_cmp++;
      if ({WB_o, wb_data_o, MemtoReg_o} !== {3'b101, 32'h9, 1'b0}) begin
         n_err++;
         $display("FAIL upper_wb: got wb=%b wbd=%h m2r=%b, required 101 wbd=9 m2r=0", WB_o,
                  wb_data_o, MemtoReg_o);
      end
      valid_i = 1'b0;
      cyc();
   endtask

   task automatic test_x0();
      ready_i = 1'b1;
      drive(1'b1, 3'b001, 32'h0, 32'h77, 5'd0);
      cyc();
      n_cmp++;
      if ({valid_o, RegWrite_o, fwd_en_o, WB_o[0]} !== 4'b1001) begin
         n_err++;
         $display("FAIL x0_write: got v/rw/fwd/wb0=%b, required 1001",
                  {valid_o, RegWrite_o, fwd_en_o, WB_o[0]});
      end
      valid_i = 1'b0;
      cyc();
      n_cmp++;
      if ({valid_o, RegWrite_o, fwd_en_o} !== 3'b000) begin
         n_err++;
         $display("FAIL bubble_gate: got v/rw/fwd=%b, required 000", {valid_o, RegWrite_o, fwd_en_o});
      end
   endtask

   task automatic test_flush();
      ready_i = 1'b0;
      drive(1'b1, 3'b001, 32'h0, 32'hF1, 5'd8);
      cyc();
      drive(1'b1, 3'b001, 32'h0, 32'hF2, 5'd8);
      cyc();
      n_cmp++;
      if ({valid_o, ready_o} !== 2'b10) begin
         n_err++;
         $display("FAIL flush_setup: got v/r=%b, required 10", {valid_o, ready_o});
      end
      drive(1'b1, 3'b001, 32'h0, 32'hDD, 5'd9);
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;
      valid_i = 1'b0;
      n_cmp++;
      if ({valid_o, ready_o} !== 2'b01) begin
         n_err++;
         $display("FAIL flush_full: got v/r=%b, required 01", {valid_o, ready_o});
      end
      ready_i = 1'b1;
      repeat (3) cyc();
      // Flush on an empty stage with a valid input must also drop that input.
      drive(1'b1, 3'b001, 32'h0, 32'hEE, 5'd9);
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;
      valid_i = 1'b0;
      n_cmp++;
      if (valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL flush_input: got valid_o=%b, required 0", valid_o);
      end
      cyc();
      n_cmp++;
      if (valid_o !== 1'b0 || sb_q.size() != 0) begin
         n_err++;
         $display("FAIL flush_after: got valid_o=%b pending=%0d, required 0 and 0",
                  valid_o, sb_q.size());
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 80; i++) begin
         ready_i = ($urandom_range(0, 2) != 0);
         drive(($urandom_range(0, 3) != 0), WW'($urandom), $urandom, $urandom, AW'($urandom));
         cyc();
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      for (int k = 0; k < 8 && valid_o; k++) cyc();
      n_cmp++;
      if (valid_o !== 1'b0 || sb_q.size() != 0) begin
         n_err++;
         $display("FAIL b2b_drain: got valid_o=%b pending=%0d, required 0 and 0 within 8 cycles",
                  valid_o, sb_q.size());
      end
   endtask

   initial begin
      flush_i = 1'b0;
      fork
         scoreboard_monitor();
      join_none
      test_reset();
      test_stream();
      test_stall();
      test_load();
      test_x0();
      test_flush();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
